// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter / fetch-sequencing stage.
//   pc_state_e    : fetch sequencer states (BOOT -> RUN -> FAULT).
//   fault_cause_e : encoding driven on the fault_cause output.
//   PC_STEP       : byte distance between sequential instructions.
//   fault_priority: folds the two target checks into one cause code.
// -----------------------------------------------------------------------------
package pc_pkg;

   // BOOT gives the synchronous ROM one cycle to present the word at the
   // reset vector before anything is allowed to commit.
   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      RUN   = 2'b01,
      FAULT = 2'b10
   } pc_state_e;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISALIGN = 2'b01,
      FC_RANGE    = 2'b10
   } fault_cause_e;

   localparam int unsigned PC_STEP = 4;

   // A misaligned target is reported even when it is also out of range.
   function automatic fault_cause_e fault_priority(input logic misaligned,
                                                   input logic out_of_range);
      fault_cause_e cause;
      if (misaligned) begin
         cause = FC_MISALIGN;
      end else if (out_of_range) begin
         cause = FC_RANGE;
      end else begin
         cause = FC_NONE;
      end
      return cause;
   endfunction

endpackage : pc_pkg

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC datapath: sequential/branch target selection
// and legality checks on that target.
//   a_i            : current PC.
//   pc_src_i       : 1 = branch (a_i + imm_op_i), 0 = sequential (a_i + 4).
//   imm_op_i       : sign-extended byte offset.
//   target_o       : candidate next PC, wraps modulo 2^DATA_WIDTH.
//   pc_plus4_o     : a_i + 4, used for link writeback.
//   misaligned_o   : target is not word aligned.
//   out_of_range_o : target lies outside [RESET_VECTOR, RESET_VECTOR+IMEM_BYTES).
// -----------------------------------------------------------------------------
module next_pc_calc
   import pc_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [DATA_WIDTH-1:0] IMEM_BYTES   = DATA_WIDTH'(32'h0000_1000)
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic                  pc_src_i,
   input  logic [DATA_WIDTH-1:0] imm_op_i,
   output logic [DATA_WIDTH-1:0] target_o,
   output logic [DATA_WIDTH-1:0] pc_plus4_o,
   output logic                  misaligned_o,
   output logic                  out_of_range_o
);

   localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

   logic [DATA_WIDTH-1:0] offset;
   logic [DATA_WIDTH-1:0] window_offset;

   // NOTE: every output of a combinational block is assigned on every path,
   // otherwise synthesis infers a latch to hold the missing value.
   always_comb begin
      pc_plus4_o     = a_i + STEP;
      offset         = pc_src_i ? imm_op_i : STEP;
      target_o       = a_i + offset;
      // Subtracting the base first turns the window test into a single
      // unsigned compare; targets below the base wrap to huge values.
      window_offset  = target_o - RESET_VECTOR;
      misaligned_o   = |target_o[1:0];
      out_of_range_o = (window_offset >= IMEM_BYTES);
   end

endmodule : next_pc_calc

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and fetch sequencer feeding the instruction ROM / control
// block. Sequences boot after reset, steps or branches the PC, honours stall,
// traps illegal fetch targets into a sticky fault, and counts retired
// instructions.
//   clk         : rising-edge clock.
//   rst         : synchronous active-high reset.
//   PCsrc       : 1 = branch to A+ImmOp, 0 = A+4.
//   ImmOp       : sign-extended byte offset.
//   stall       : hold the PC this cycle.
//   A           : current PC / instruction address.
//   PCplus4     : A+4, combinational.
//   valid       : instruction at A is live and may commit.
//   fault       : sticky fetch fault.
//   fault_cause : 00 none, 01 misaligned target, 10 out-of-range target.
//   instret     : retired-instruction count.
// -----------------------------------------------------------------------------
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [DATA_WIDTH-1:0] IMEM_BYTES   = DATA_WIDTH'(32'h0000_1000)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  PCsrc,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   input  logic                  stall,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] PCplus4,
   output logic                  valid,
   output logic                  fault,
   output logic [1:0]            fault_cause,
   output logic [DATA_WIDTH-1:0] instret
);

   pc_state_e             state_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] pc_d;
   logic [DATA_WIDTH-1:0] instret_q;
   logic [DATA_WIDTH-1:0] instret_d;
   logic                  valid_q;
   logic                  fault_q;
   fault_cause_e          cause_q;
   fault_cause_e          cause_d;

   logic                  advance;
   logic                  pc_src_m;
   logic [DATA_WIDTH-1:0] imm_op_m;
   logic                  misaligned;
   logic                  out_of_range;

   // Only a RUN cycle without stall looks at the branch inputs. Masking them
   // everywhere else keeps an undriven PCsrc/ImmOp from reaching the adder.
   assign advance  = (state_q == RUN) && !stall;
   assign pc_src_m = advance & PCsrc;
   assign imm_op_m = advance ? ImmOp : '0;

   next_pc_calc #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VECTOR(RESET_VECTOR),
      .IMEM_BYTES  (IMEM_BYTES)
   ) u_next_pc_calc (
      .a_i           (pc_q),
      .pc_src_i      (pc_src_m),
      .imm_op_i      (imm_op_m),
      .target_o      (pc_d),
      .pc_plus4_o    (PCplus4),
      .misaligned_o  (misaligned),
      .out_of_range_o(out_of_range)
   );

   assign instret_d = instret_q + DATA_WIDTH'(1);
   assign cause_d   = fault_priority(misaligned, out_of_range);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= BOOT;
         pc_q      <= RESET_VECTOR;
         instret_q <= '0;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
         cause_q   <= FC_NONE;
      end else begin
         unique case (state_q)
            BOOT: begin
               state_q <= RUN;
               valid_q <= 1'b1;
            end
            RUN: begin
               if (!stall) begin
                  if (cause_d != FC_NONE) begin
                     // PC stays on the instruction whose successor was illegal.
                     state_q <= FAULT;
                     valid_q <= 1'b0;
                     fault_q <= 1'b1;
                     cause_q <= cause_d;
                  end else begin
                     pc_q      <= pc_d;
                     instret_q <= instret_d;
                  end
               end
            end
            FAULT: begin
               // Sticky: only reset leaves this state.
               state_q <= FAULT;
            end
            default: begin
               // Unreachable encoding: restart the boot sequence.
               state_q <= BOOT;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign A           = pc_q;
   assign valid       = valid_q;
   assign fault       = fault_q;
   assign fault_cause = cause_q;
   assign instret     = instret_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed scenarios plus a randomized run checked against a behavioural model
// of the fetch unit built directly from its architectural rules.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam logic [31:0] IMEM = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        PCsrc;
   logic [31:0] ImmOp;
   logic        stall;
   logic [31:0] A;
   logic [31:0] PCplus4;
   logic        valid;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] instret;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic [31:0] m_instret;
   logic        m_valid;
   logic        m_fault;
   logic        m_booting;
   logic [1:0]  m_cause;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .DATA_WIDTH  (32),
      .RESET_VECTOR(RV),
      .IMEM_BYTES  (IMEM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .PCsrc      (PCsrc),
      .ImmOp      (ImmOp),
      .stall      (stall),
      .A          (A),
      .PCplus4    (PCplus4),
      .valid      (valid),
      .fault      (fault),
      .fault_cause(fault_cause),
      .instret    (instret)
   );

   // Apply inputs for one edge, advance the model by the same edge, then
   // leave the caller 1 time unit after the edge to sample outputs.
   task automatic step(input logic r, input logic ps, input logic [31:0] im,
                       input logic st);
      logic [31:0] nxt;
      rst   = r;
      PCsrc = ps;
      ImmOp = im;
      stall = st;
      @(posedge clk);
      #1;
      if (r) begin
         m_pc = RV; m_instret = 0; m_valid = 0; m_fault = 0; m_booting = 1; m_cause = 0;
      end else if (m_fault) begin
         // frozen
      end else if (m_booting) begin
         m_booting = 0;
         m_valid   = 1;
      end else if (!st) begin
         nxt = m_pc + (ps ? im : 32'd4);
         if ((nxt % 4) != 0) begin
            m_fault = 1; m_valid = 0; m_cause = 2'd1;
         end else if ((nxt - RV) >= IMEM) begin
            m_fault = 1; m_valid = 0; m_cause = 2'd2;
         end else begin
            m_pc      = nxt;
            m_instret = m_instret + 1;
         end
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (A !== 32'h0) begin errors++; $display("FAIL reset_A got=%h exp=%h", A, 32'h0); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin errors++; $display("FAIL reset_fault got=%b/%b exp=0/00", fault, fault_cause); end
      checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
      // BOOT edge: branch and stall must be ignored.
      step(1'b0, 1'b1, 32'h40, 1'b1);
      checks++; if (A !== 32'h0 || valid !== 1'b1 || instret !== 32'h0) begin
         errors++; $display("FAIL boot_exit got A=%h valid=%b instret=%0d exp A=0 valid=1 instret=0", A, valid, instret);
      end
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         checks++; if (A !== 32'(i * 4) || PCplus4 !== 32'(i * 4 + 4)) begin
            errors++; $display("FAIL seq_step%0d got A=%h PCplus4=%h exp %h/%h", i, A, PCplus4, i * 4, i * 4 + 4);
         end
      end
      checks++; if (instret !== 32'd3) begin errors++; $display("FAIL seq_instret got=%0d exp=3", instret); end
   endtask

   task automatic test_branch();
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (A !== 32'h10) begin errors++; $display("FAIL br_setup_A got=%h exp=10", A); end
      step(1'b0, 1'b1, 32'h20, 1'b0);
      checks++; if (A !== 32'h30 || instret !== 32'd5) begin errors++; $display("FAIL br_fwd got A=%h instret=%0d exp 30/5", A, instret); end
      step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0);
      checks++; if (A !== 32'h20 || instret !== 32'd6) begin errors++; $display("FAIL br_back got A=%h instret=%0d exp 20/6", A, instret); end
   endtask

   task automatic test_stall();
      do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (A !== 32'h8) begin errors++; $display("FAIL stall_setup_A got=%h exp=8", A); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 32'h40, 1'b1);
         checks++; if (A !== 32'h8 || instret !== 32'd2 || valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold%0d got A=%h instret=%0d valid=%b exp 8/2/1", i, A, instret, valid);
         end
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (A !== 32'hC || instret !== 32'd3) begin errors++; $display("FAIL stall_release got A=%h instret=%0d exp C/3", A, instret); end
   endtask

   task automatic test_misalign();
      do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h2, 1'b0);
      checks++; if (fault !== 1'b1 || fault_cause !== 2'b01 || valid !== 1'b0 || A !== 32'h4) begin
         errors++; $display("FAIL misalign got fault=%b cause=%b valid=%b A=%h exp 1/01/0/4", fault, fault_cause, valid, A);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'($urandom), $urandom, 1'($urandom));
         checks++; if (fault !== 1'b1 || fault_cause !== 2'b01 || valid !== 1'b0 || A !== 32'h4 || instret !== 32'd1) begin
            errors++; $display("FAIL misalign_sticky%0d got fault=%b cause=%b valid=%b A=%h instret=%0d", i, fault, fault_cause, valid, A, instret);
         end
      end
      step(1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (fault !== 1'b0 || fault_cause !== 2'b00 || A !== 32'h0) begin
         errors++; $display("FAIL misalign_clear got fault=%b cause=%b A=%h exp 0/00/0", fault, fault_cause, A);
      end
   endtask

   task automatic test_range();
      do_reset();
      step(1'b0, 1'b1, 32'hFFC, 1'b0);
      checks++; if (A !== 32'hFFC) begin errors++; $display("FAIL range_setup_A got=%h exp=FFC", A); end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (fault !== 1'b1 || fault_cause !== 2'b10 || A !== 32'hFFC || valid !== 1'b0) begin
         errors++; $display("FAIL range_top got fault=%b cause=%b A=%h valid=%b exp 1/10/FFC/0", fault, fault_cause, A, valid);
      end
      do_reset();
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      checks++; if (fault !== 1'b1 || fault_cause !== 2'b10 || A !== 32'h0) begin
         errors++; $display("FAIL range_below got fault=%b cause=%b A=%h exp 1/10/0", fault, fault_cause, A);
      end
      // Both checks fail: misalignment wins.
      do_reset();
      step(1'b0, 1'b1, 32'h2001, 1'b0);
      checks++; if (fault_cause !== 2'b01) begin errors++; $display("FAIL range_priority got cause=%b exp=01", fault_cause); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b0, 1'b1, 32'h20, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (A !== 32'h20) begin errors++; $display("FAIL rmid_setup_A got=%h exp=20", A); end
      step(1'b1, 1'b1, 32'h8, 1'b1);
      checks++; if (A !== 32'h0 || valid !== 1'b0 || instret !== 32'h0 || fault !== 1'b0) begin
         errors++; $display("FAIL rmid_stall got A=%h valid=%b instret=%0d fault=%b exp 0/0/0/0", A, valid, instret, fault);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h6, 1'b0);
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL rmid_enter_fault got fault=%b exp=1", fault); end
      step(1'b1, 1'b1, 32'h6, 1'b0);
      checks++; if (A !== 32'h0 || valid !== 1'b0 || instret !== 32'h0 || fault !== 1'b0 || fault_cause !== 2'b00) begin
         errors++; $display("FAIL rmid_fault got A=%h valid=%b instret=%0d fault=%b cause=%b", A, valid, instret, fault, fault_cause);
      end
   endtask

   task automatic test_random();
      logic        r;
      logic        ps;
      logic        st;
      logic [31:0] im;
      int          sel;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 99) < 3);
         ps  = ($urandom_range(0, 2) == 0);
         st  = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 99);
         if (sel < 70)      im = 32'($urandom_range(0, 127) * 4) - 32'd256;
         else if (sel < 85) im = 32'($urandom_range(0, 63)) - 32'd32;
         else               im = $urandom;
         step(r, ps, im, st);
         checks++;
         if ({A, PCplus4, instret, valid, fault, fault_cause} !==
             {m_pc, m_pc + 32'd4, m_instret, m_valid, m_fault, m_cause}) begin
            errors++;
            $display("FAIL rand%0d got A=%h P4=%h ir=%0d v=%b f=%b c=%b exp A=%h ir=%0d v=%b f=%b c=%b",
                     i, A, PCplus4, instret, valid, fault, fault_cause,
                     m_pc, m_instret, m_valid, m_fault, m_cause);
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      PCsrc = 1'b0;
      ImmOp = 32'h0;
      stall = 1'b0;
      test_reset();
      test_branch();
      test_stall();
      test_misalign();
      test_range();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pc_fetch_unit

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the control top.
- Drives the instruction address A into the instruction ROM/control block, and consumes PCsrc and ImmOp coming back from it.
- Computes the next PC (sequential or branch), sequences boot after reset, supports pipeline stall, and traps illegal fetch targets into a sticky fault state.
- Keeps a retired-instruction counter for bring-up and debug.

Parameters:
- DATA_WIDTH, 32: width of PC, ImmOp and counter.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- IMEM_BYTES, 32'h0000_1000: size of the instruction ROM window in bytes. Legal fetch range is [RESET_VECTOR, RESET_VECTOR+IMEM_BYTES).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- PCsrc  in  1  1 = take branch target PC+ImmOp; 0 = PC+4.
- ImmOp  in  DATA_WIDTH  sign-extended byte offset from the extend unit.
- stall  in  1  hold PC this cycle.
- A  out  DATA_WIDTH  current PC / instruction address to the ROM.
- PCplus4  out  DATA_WIDTH  A+4, combinational, for link writeback.
- valid  out  1  instruction at A is live and may commit.
- fault  out  1  sticky fetch fault.
- fault_cause  out  2  00 none, 01 misaligned target, 10 out-of-range target.
- instret  out  DATA_WIDTH  retired-instruction count.

Behaviour:
- Clocking and reset:
  - All state updates on rising clk; one clock domain; reset is synchronous and active-high.
  - rst=1 at an edge forces: A=RESET_VECTOR, state=BOOT, valid=0, fault=0, fault_cause=00, instret=0.
  - rst overrides every other input, including while in FAULT or mid-stall.
- States:
  - BOOT: entered from reset.
    - Holds one cycle so the synchronous ROM read of RESET_VECTOR settles.
    - valid=0; A held; instret held; PCsrc and stall ignored.
    - Goes unconditionally to RUN.
  - RUN: valid=1. Next-PC priority per edge:
    - stall=1: A held, instret held. PCsrc/ImmOp ignored, so a branch must be re-presented once the stall drops.
    - else compute target: PCsrc ? A+ImmOp : A+4, with modulo 2^DATA_WIDTH wrap (0xFFFF_FFFC+4 = 0).
    - target[1:0]!=0: go to FAULT, cause=01, A held, instret not incremented.
    - else target outside the legal window (unsigned compare on target-RESET_VECTOR >= IMEM_BYTES): go to FAULT, cause=10, A held, instret not incremented.
    - else A<=target, instret<=instret+1 (wraps at 2^DATA_WIDTH).
  - FAULT:
    - valid=0, fault=1, fault_cause held, A frozen at the offending instruction's PC.
    - instret frozen; all inputs ignored.
    - Exits only via rst.
- The misaligned check has priority over the range check when both fail.
- Latency: a new PC is visible on A one cycle after the deciding edge. PCplus4 is combinational from A with zero latency.
- fault and fault_cause are registered, asserting the cycle after the illegal decision. valid drops in that same cycle.
- Negative ImmOp (backward branch) uses two's-complement addition. A backward branch below RESET_VECTOR wraps in the unsigned subtraction and therefore faults with cause 10.
- No X may propagate from PCsrc/ImmOp while stall=1, in BOOT, or in FAULT: those inputs are masked.

Decomposition:
- Package pc_pkg holds:
  - state enum {BOOT, RUN, FAULT};
  - fault_cause enum {FC_NONE=2'b00, FC_MISALIGN=2'b01, FC_RANGE=2'b10};
  - constant PC_STEP=4.
- One combinational sub-module, next_pc_calc:
  - inputs A, PCsrc, ImmOp, RESET_VECTOR/IMEM_BYTES as parameters;
  - outputs target, PCplus4, misaligned, out_of_range.
- The top holds the FSM, PC register and counter.

Test Plan:
- Reset/boot: assert rst 2 cycles, release.
  - Expect A=0, valid=0 for the first cycle.
  - Then valid=1 and A stepping 0,4,8,12 on successive edges; instret=3 after the third step.
- Branch forward and backward: at A=0x10, PCsrc=1, ImmOp=0x20 → A=0x30. Then PCsrc=1, ImmOp=0xFFFF_FFF0 → A=0x20. instret increments on each.
- Stall: at A=0x8, stall=1 for 3 cycles with PCsrc=1, ImmOp=0x40.
  - Expect A=0x8 and instret unchanged throughout.
  - After release with PCsrc=0, A=0xC.
- Misaligned fault: at A=0x4, PCsrc=1, ImmOp=0x2.
  - Next cycle: fault=1, fault_cause=01, valid=0, A=0x4.
  - Stays there for 10 cycles of random inputs.
  - rst then clears fault and A=0.
- Out-of-range fault: IMEM_BYTES=0x1000; at A=0xFFC, PCsrc=0 → fault=1, cause=10, A=0xFFC. Separately, at A=0x0 with ImmOp=0xFFFF_FFFC → cause=10.
- Reset mid-stall and mid-fault: assert rst while stall=1 at A=0x20, and again while in FAULT. Both return A=0, state BOOT, instret=0, fault=0 one edge later.
